// File: rtl/mips_debug_ctrl.sv
// Host debug controller: program load, run/step control and register dump.
// Optional `DBG_CYCLE_COUNT_EN` adds a pipeline cycle counter read by 'C'.
module mips_debug_ctrl #(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_imem_we,
    output logic [IMEM_AW-1:0] o_imem_addr,
    output logic [31:0]        o_imem_wdata,
    output logic               o_pipe_en,
    input  logic               i_halt,
    output logic [4:0]         o_rf_addr,
    input  logic [31:0]        i_rf_data
);

    typedef enum logic [3:0] {
        IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR,
        RUN, STEP, DUMP_RD, DUMP_TX, ACK
    } state_t;

    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] R_OK  = 8'hAA;
    localparam logic [7:0] R_ERR = 8'hEE;

    state_t state, nstate;

    logic [8:0]         n_left;
    logic [IMEM_AW-1:0] addr;
    logic [1:0]         bidx;
    logic [31:0]        word;
    logic [4:0]         ridx;
    logic               rd_ph;
    logic               cnt_mode;
    logic [7:0]         reply;

    logic rdy, txv, we, pen;
    logic [7:0] txd;
    logic rx_fire, tx_fire;
    logic is_l, is_c, cmd_ok;

    assign rx_fire = i_rx_valid & o_rx_ready;
    assign tx_fire = o_tx_valid & i_tx_ready;

    assign is_l = (i_rx_data == CMD_L);
`ifdef DBG_CYCLE_COUNT_EN
    assign is_c = (i_rx_data == CMD_C);
`else
    assign is_c = 1'b0;
`endif
    assign cmd_ok = is_l | is_c
                  | (i_rx_data == CMD_R)
                  | (i_rx_data == CMD_S)
                  | (i_rx_data == CMD_D);

    // Outputs are forced quiet while reset is held so nothing leaks out
    assign o_rx_ready   = reset & rdy;
    assign o_tx_valid   = reset & txv;
    assign o_imem_we    = reset & we;
    assign o_pipe_en    = reset & pen;
    assign o_tx_data    = txd;
    assign o_imem_addr  = addr;
    assign o_imem_wdata = word;
    assign o_rf_addr    = ridx;

`ifdef DBG_CYCLE_COUNT_EN
    logic [31:0] cyc;

    // Pipeline cycle counter, restarted by each program load
    always_ff @(posedge clk) begin
        if (!reset)
            cyc <= '0;
        else if (state == IDLE && rx_fire && is_l)
            cyc <= '0;
        else if (o_pipe_en)
            cyc <= cyc + 32'd1;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= nstate;
    end

    // Next-state and handshake/strobe decode
    always_comb begin
        nstate = state;
        rdy    = 1'b0;
        txv    = 1'b0;
        txd    = 8'h00;
        we     = 1'b0;
        pen    = 1'b0;
        unique case (state)
            IDLE: begin
                rdy = 1'b1;
                if (rx_fire) begin
                    unique case (1'b1)
                        is_l:                   nstate = LOAD_CNT;
                        is_c:                   nstate = DUMP_TX;
                        (i_rx_data == CMD_R):   nstate = RUN;
                        (i_rx_data == CMD_S):   nstate = STEP;
                        (i_rx_data == CMD_D):   nstate = DUMP_RD;
                        default:                nstate = ACK;
                    endcase
                end
            end
            LOAD_CNT: begin
                rdy = 1'b1;
                if (rx_fire) nstate = LOAD_BYTE;
            end
            LOAD_BYTE: begin
                rdy = 1'b1;
                if (rx_fire && bidx == 2'd3) nstate = LOAD_WR;
            end
            LOAD_WR: begin
                we     = 1'b1;
                nstate = (n_left == 9'd1) ? ACK : LOAD_BYTE;
            end
            RUN: begin
                pen = ~i_halt;
                if (i_halt) nstate = ACK;
            end
            STEP: begin
                pen    = 1'b1;
                nstate = ACK;
            end
            DUMP_RD: begin
                if (rd_ph) nstate = DUMP_TX;
            end
            DUMP_TX: begin
                txv = 1'b1;
                txd = word[31:24];
                if (tx_fire && bidx == 2'd3)
                    nstate = (cnt_mode || ridx == 5'd31) ? ACK : DUMP_RD;
            end
            ACK: begin
                txv = 1'b1;
                txd = reply;
                if (tx_fire) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    // Counters, word assembly/shift register and reply byte
    always_ff @(posedge clk) begin
        if (!reset) begin
            n_left   <= '0;
            addr     <= '0;
            bidx     <= '0;
            word     <= '0;
            ridx     <= '0;
            rd_ph    <= 1'b0;
            cnt_mode <= 1'b0;
            reply    <= R_OK;
        end else begin
            unique case (state)
                IDLE: if (rx_fire) begin
                    bidx     <= '0;
                    ridx     <= '0;
                    rd_ph    <= 1'b0;
                    addr     <= '0;
                    cnt_mode <= is_c;
                    reply    <= cmd_ok ? R_OK : R_ERR;
`ifdef DBG_CYCLE_COUNT_EN
                    if (is_c) word <= cyc;
`endif
                end
                LOAD_CNT: if (rx_fire)
                    n_left <= (i_rx_data == 8'h00) ? 9'd256 : {1'b0, i_rx_data};
                LOAD_BYTE: if (rx_fire) begin
                    word <= {word[23:0], i_rx_data};
                    bidx <= bidx + 2'd1;
                end
                LOAD_WR: begin
                    addr   <= addr + 1'b1;
                    n_left <= n_left - 9'd1;
                end
                DUMP_RD: begin
                    rd_ph <= ~rd_ph;
                    if (rd_ph) begin
                        word <= i_rf_data;
                        bidx <= '0;
                    end
                end
                DUMP_TX: if (tx_fire) begin
                    word <= {word[23:0], 8'h00};
                    bidx <= bidx + 2'd1;
                    if (bidx == 2'd3 && !cnt_mode && ridx != 5'd31)
                        ridx <= ridx + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Directed bench for mips_debug_ctrl: command vectors plus load, run,
// dump and reset-abort sequences. Define DBG_CYCLE_COUNT_EN to match the DUT.
module tb_mips_debug_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_imem_we;
    logic [7:0]  o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_pipe_en;
    logic        i_halt;
    logic [4:0]  o_rf_addr;
    logic [31:0] i_rf_data;

    int checks = 0;
    int errors = 0;
    int we_total = 0;
    int pen_total = 0;
    int stab_err = 0;
    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    logic tr_phase = 1'b1;
    logic last_hold = 1'b0;
    logic [7:0] held = 8'h00;

    always #5 clk = ~clk;

    mips_debug_ctrl #(.IMEM_AW(8)) dut (
        .clk(clk), .reset(reset),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
        .o_pipe_en(o_pipe_en), .i_halt(i_halt),
        .o_rf_addr(o_rf_addr), .i_rf_data(i_rf_data)
    );

    // Register file model: r holds r*4, one cycle read latency
    always @(posedge clk) i_rf_data <= {25'd0, o_rf_addr, 2'b00};

    // Strobe monitors
    always @(negedge clk) begin
        if (o_imem_we) begin
            we_total++;
            wa.push_back(o_imem_addr);
            wd.push_back(o_imem_wdata);
        end
        if (o_pipe_en) pen_total++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bit acc = 0;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        while (!acc && n < 100) begin
            @(negedge clk);
            if (o_rx_ready) acc = 1;
            @(posedge clk); #1;
            n++;
        end
        i_rx_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'(b), 32'hFFFF_FFFF);
    endtask

    task automatic recv(input logic [7:0] exp, input string nm, input bit toggle);
        int n = 0;
        bit got = 0;
        while (!got && n < 400) begin
            i_tx_ready = toggle ? tr_phase : 1'b1;
            tr_phase = ~tr_phase;
            @(negedge clk);
            if (o_tx_valid && last_hold && o_tx_data !== held) stab_err++;
            if (o_tx_valid && i_tx_ready) begin
                chk(nm, 32'(o_tx_data), 32'(exp));
                got = 1;
                last_hold = 1'b0;
            end else if (o_tx_valid) begin
                held = o_tx_data;
                last_hold = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        i_tx_ready = 1'b0;
        if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic       halt;
        logic [7:0] reply;
        int         pens;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int en;
        int p0;
        int w0;
        bit seen;

        tbl[0] = '{8'h52, 1'b1, 8'hAA, 0};
        tbl[1] = '{8'h53, 1'b0, 8'hAA, 1};
        tbl[2] = '{8'h53, 1'b1, 8'hAA, 1};
        tbl[3] = '{8'h53, 1'b0, 8'hAA, 1};
        tbl[4] = '{8'h58, 1'b0, 8'hEE, 0};
        tbl[5] = '{8'h00, 1'b0, 8'hEE, 0};

        reset = 1'b0;
        i_rx_data = 8'h00;
        i_rx_valid = 1'b0;
        i_tx_ready = 1'b0;
        i_halt = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("rst_imem_we", 32'(o_imem_we), 32'd0);
        chk("rst_pipe_en", 32'(o_pipe_en), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rx_ready", 32'(o_rx_ready), 32'd1);
        @(posedge clk); #1;

        // Load two words
        send(8'h4C); send(8'h02);
        send(8'h00); send(8'h00); send(8'h00); send(8'h01);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78);
        recv(8'hAA, "load_reply", 1'b0);
        chk("load_we_cycles", 32'(we_total), 32'd2);
        if (wa.size() == 2) begin
            chk("load_a0", 32'(wa[0]), 32'd0);
            chk("load_d0", wd[0], 32'h0000_0001);
            chk("load_a1", 32'(wa[1]), 32'd1);
            chk("load_d1", wd[1], 32'h1234_5678);
        end

        // Run until halt after seven enables
        send(8'h52);
        en = 0;
        seen = 0;
        i_halt = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (o_tx_valid) seen = 1;
            if (o_pipe_en) en++;
            @(posedge clk); #1;
            if (en == 7) i_halt = 1'b1;
        end
        chk("run_enables", 32'(en), 32'd7);
        recv(8'hAA, "run_reply", 1'b0);
        i_halt = 1'b0;

`ifdef DBG_CYCLE_COUNT_EN
        send(8'h43);
        recv(8'h00, "cyc_b3", 1'b0);
        recv(8'h00, "cyc_b2", 1'b0);
        recv(8'h00, "cyc_b1", 1'b0);
        recv(8'h07, "cyc_b0", 1'b0);
        recv(8'hAA, "cyc_ack", 1'b0);
`else
        send(8'h43);
        recv(8'hEE, "c_unknown", 1'b0);
`endif

        // Single-byte command vectors
        for (int i = 0; i < 6; i++) begin
            i_halt = tbl[i].halt;
            p0 = pen_total;
            send(tbl[i].cmd);
            recv(tbl[i].reply, $sformatf("vec%0d_reply", i), 1'b0);
            chk($sformatf("vec%0d_pens", i), 32'(pen_total - p0), 32'(tbl[i].pens));
        end
        i_halt = 1'b0;

        // Register dump with throttled tx
        send(8'h44);
        stab_err = 0;
        for (int r = 0; r < 32; r++) begin
            recv(8'h00, $sformatf("dump_r%0d_b3", r), 1'b1);
            recv(8'h00, $sformatf("dump_r%0d_b2", r), 1'b1);
            recv(8'h00, $sformatf("dump_r%0d_b1", r), 1'b1);
            recv(8'(r * 4), $sformatf("dump_r%0d_b0", r), 1'b1);
        end
        recv(8'hAA, "dump_ack", 1'b1);
        chk("dump_stable", 32'(stab_err), 32'd0);

        // Reset during the third data byte of a load
        w0 = we_total;
        send(8'h4C); send(8'h01);
        send(8'h00); send(8'h00);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h11;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rx_ready", 32'(o_rx_ready), 32'd0);
        chk("abort_tx_valid", 32'(o_tx_valid), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rx_ready_rel", 32'(o_rx_ready), 32'd1);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_write", 32'(we_total - w0), 32'd0);
        send(8'h58);
        recv(8'hEE, "post_abort_x", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
